am_search_ctrl: RTL



---
 rtl/am_pkg.sv | 17 +
 rtl/am_argmax_seq.sv | 61 ++++++
 rtl/am_search_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/am_pkg.sv
// Shared constants and FSM state type for the associative-memory search controller.
package am_pkg;
  localparam int NUM_CLASSES     = 26;
  localparam int SEQ_CYCLE_COUNT = 4;
  localparam int DIMS_PER_CC     = 1024;
  localparam int SCORE_W         = 13;
  localparam int POP_W           = 11;
  localparam int CLASS_W         = 5;
  localparam int QCTR_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEG    = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_DONE   = 2'd3
  } am_state_e;
endpackage

// File: rtl/am_argmax_seq.sv
// Sequential arg-max: walks one class per step, keeping the first strictly-largest score.
module am_argmax_seq #(
  parameter int NUM_CLASSES = am_pkg::NUM_CLASSES,
  parameter int SCORE_W     = am_pkg::SCORE_W,
  parameter int CLASS_W     = am_pkg::CLASS_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                step,
  input  logic [NUM_CLASSES-1:0][SCORE_W-1:0] scores,
  output logic                                last,
  output logic [CLASS_W-1:0]                  best_class,
  output logic [SCORE_W-1:0]                  best_score
);
  logic [CLASS_W-1:0] idx_q, idx_d;
  logic [CLASS_W-1:0] best_class_q, best_class_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [SCORE_W-1:0] cand;

  assign cand       = scores[idx_q];
  assign last       = (idx_q == CLASS_W'(NUM_CLASSES - 1));
  assign best_class = best_class_q;
  assign best_score = best_score_q;

  // Next-state for the scan index and running best; strict compare keeps the lowest index on ties.
  always_comb begin
    idx_d        = idx_q;
    best_class_d = best_class_q;
    best_score_d = best_score_q;
    if (clear) begin
      idx_d        = {CLASS_W{1'b0}};
      best_class_d = {CLASS_W{1'b0}};
      best_score_d = {SCORE_W{1'b0}};
    end else if (step) begin
      if (cand > best_score_q) begin
        best_class_d = idx_q;
        best_score_d = cand;
      end else begin
        best_class_d = best_class_q;
        best_score_d = best_score_q;
      end
      idx_d = last ? {CLASS_W{1'b0}} : idx_q + CLASS_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Scan registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= {CLASS_W{1'b0}};
      best_class_q <= {CLASS_W{1'b0}};
      best_score_q <= {SCORE_W{1'b0}};
    end else begin
      idx_q        <= idx_d;
      best_class_q <= best_class_d;
      best_score_q <= best_score_d;
    end
  end
endmodule

// File: rtl/am_search_ctrl.sv
// Search controller: accumulates per-class popcounts over the query segments,
// then runs a sequential arg-max and presents the winner on a valid/ready port.
module am_search_ctrl #(
  parameter int  NUM_CLASSES     = am_pkg::NUM_CLASSES,
  parameter int  SEQ_CYCLE_COUNT = am_pkg::SEQ_CYCLE_COUNT,
  parameter int  DIMS_PER_CC     = am_pkg::DIMS_PER_CC,
  localparam int POP_W           = $clog2(DIMS_PER_CC) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic                            abort,
  output logic [am_pkg::QCTR_W-1:0]       query_ctr,
  output logic                            seg_en,
  input  logic [NUM_CLASSES*POP_W-1:0]    seg_popcnt,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [am_pkg::CLASS_W-1:0]      result_class,
  output logic [am_pkg::SCORE_W-1:0]      result_score,
  output logic                            busy
);
  import am_pkg::*;

  am_state_e                           state_q, state_d;
  logic [QCTR_W-1:0]                   query_ctr_q, query_ctr_d;
  logic [NUM_CLASSES-1:0][SCORE_W-1:0] score_q, score_d;
  logic                                clear_scan;
  logic                                step_scan;
  logic                                scan_last;

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign seg_en       = (state_q == ST_SEG);
  assign result_valid = (state_q == ST_DONE);
  assign query_ctr    = query_ctr_q;

  // FSM next-state, segment counter and score accumulation.
  always_comb begin
    state_d     = state_q;
    query_ctr_d = query_ctr_q;
    score_d     = score_q;
    clear_scan  = 1'b0;
    step_scan   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d     = ST_SEG;
          query_ctr_d = {QCTR_W{1'b0}};
          score_d     = '0;
          clear_scan  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEG: begin
        if (abort) begin
          state_d     = ST_IDLE;
          query_ctr_d = {QCTR_W{1'b0}};
        end else begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            score_d[i] = score_q[i] + SCORE_W'(seg_popcnt[i*POP_W +: POP_W]);
          end
          if (query_ctr_q == QCTR_W'(SEQ_CYCLE_COUNT - 1)) begin
            state_d     = ST_ARGMAX;
            query_ctr_d = {QCTR_W{1'b0}};
          end else begin
            query_ctr_d = query_ctr_q + QCTR_W'(1);
          end
        end
      end
      ST_ARGMAX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          step_scan = 1'b1;
          state_d   = scan_last ? ST_DONE : ST_ARGMAX;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        query_ctr_d = {QCTR_W{1'b0}};
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      query_ctr_q <= {QCTR_W{1'b0}};
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      query_ctr_q <= query_ctr_d;
      score_q     <= score_d;
    end
  end

  am_argmax_seq #(
    .NUM_CLASSES (NUM_CLASSES),
    .SCORE_W     (SCORE_W),
    .CLASS_W     (CLASS_W)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_scan),
    .step       (step_scan),
    .scores     (score_q),
    .last       (scan_last),
    .best_class (result_class),
    .best_score (result_score)
  );
endmodule
